// File: rtl/data_sram_bridge_pkg.sv
// Shared types and helpers for the memory-stage to data-SRAM bus bridge.
package data_sram_bridge_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    DATA,
    DONE,
    DRAIN
  } bridge_state_t;

  localparam logic [1:0] BUS_SZ_BYTE = 2'd0;
  localparam logic [1:0] BUS_SZ_HALF = 2'd1;
  localparam logic [1:0] BUS_SZ_WORD = 2'd2;

  // One lane -> byte, two lanes -> half; reads (no lanes) and full words use word size.
  function automatic logic [1:0] wen_to_size(input logic [3:0] wen);
    logic [2:0] cnt;
    cnt = 3'(wen[0]) + 3'(wen[1]) + 3'(wen[2]) + 3'(wen[3]);
    case (cnt)
      3'd1:    return BUS_SZ_BYTE;
      3'd2:    return BUS_SZ_HALF;
      default: return BUS_SZ_WORD;
    endcase
  endfunction

endpackage

// File: rtl/data_sram_bridge.sv
// Single-outstanding bridge: captures a memory-stage access, runs the
// req/addr_ok/data_ok handshake, stalls until done, and drains flushed accesses.
module data_sram_bridge
  import data_sram_bridge_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                mem_en,
  input  logic [DATA_W/8-1:0] mem_wen,
  input  logic [ADDR_W-1:0]   mem_addr,
  input  logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W-1:0]   mem_rdata,
  input  logic                hold,
  input  logic                flush,
  output logic                stall,
  output logic                bus_req,
  output logic                bus_wr,
  output logic [1:0]          bus_size,
  output logic [ADDR_W-1:0]   bus_addr,
  output logic [DATA_W-1:0]   bus_wdata,
  output logic [DATA_W/8-1:0] bus_wstrb,
  input  logic                bus_addr_ok,
  input  logic                bus_data_ok,
  input  logic [DATA_W-1:0]   bus_rdata
);

  bridge_state_t       state_q, state_d;
  logic                wr_q, wr_d;
  logic [1:0]          size_q, size_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W/8-1:0] wstrb_q, wstrb_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      wr_q    <= 1'b0;
      size_q  <= 2'd0;
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      wr_q    <= wr_d;
      size_q  <= size_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
      rdata_q <= rdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    wr_d    = wr_q;
    size_d  = size_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wstrb_d = wstrb_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: begin
        if (mem_en && !flush) begin
          state_d = ADDR;
          wr_d    = |mem_wen;
          size_d  = wen_to_size(mem_wen);
          addr_d  = mem_addr;
          wdata_d = mem_wdata;
          wstrb_d = mem_wen;
        end
      end
      ADDR: begin
        if (bus_addr_ok) begin
          // A flushed access whose data already returned has nothing left to drain.
          if (bus_data_ok) begin
            if (flush) begin
              state_d = IDLE;
            end else begin
              state_d = DONE;
              rdata_d = bus_rdata;
            end
          end else begin
            state_d = flush ? DRAIN : DATA;
          end
        end else if (flush) begin
          state_d = IDLE;
        end
      end
      DATA: begin
        if (bus_data_ok) begin
          if (flush) begin
            state_d = IDLE;
          end else begin
            state_d = DONE;
            rdata_d = bus_rdata;
          end
        end else if (flush) begin
          state_d = DRAIN;
        end
      end
      DONE: begin
        if (flush || !hold) begin
          state_d = IDLE;
        end
      end
      DRAIN: begin
        if (bus_data_ok) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus_req   = (state_q == ADDR);
  assign bus_wr    = wr_q;
  assign bus_size  = size_q;
  assign bus_addr  = addr_q;
  assign bus_wdata = wdata_q;
  assign bus_wstrb = wstrb_q;
  assign mem_rdata = rdata_q;

  // Gated by rst so the stall drops the instant reset asserts.
  assign stall = rst && ((state_q == ADDR) || (state_q == DATA) || (state_q == DRAIN) ||
                         ((state_q == IDLE) && mem_en && !flush));

endmodule

// File: tb/tb_data_sram_bridge.sv
// Directed bench with a timeline model of each access and a per-cycle checker.
module tb_data_sram_bridge;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        mem_en = 1'b0;
  logic [3:0]  mem_wen = '0;
  logic [31:0] mem_addr = '0;
  logic [31:0] mem_wdata = '0;
  logic [31:0] mem_rdata;
  logic        hold = 1'b0;
  logic        flush = 1'b0;
  logic        stall;
  logic        bus_req;
  logic        bus_wr;
  logic [1:0]  bus_size;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_wstrb;
  logic        bus_addr_ok = 1'b0;
  logic        bus_data_ok = 1'b0;
  logic [31:0] bus_rdata = '0;

  data_sram_bridge #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .mem_en(mem_en), .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .hold(hold), .flush(flush), .stall(stall),
    .bus_req(bus_req), .bus_wr(bus_wr), .bus_size(bus_size), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_wstrb(bus_wstrb),
    .bus_addr_ok(bus_addr_ok), .bus_data_ok(bus_data_ok), .bus_rdata(bus_rdata)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [1:0] exp_size(input logic [3:0] w);
    case ($countones(w))
      1:       return 2'd0;
      2:       return 2'd1;
      default: return 2'd2;
    endcase
  endfunction

  // Timeline model of the access currently being run.
  bit          m_active = 1'b0;
  string       m_name = "";
  int          m_t = 0;
  int          m_t_end = 0;
  int          m_req_last = 0;
  bit          m_cap = 1'b0;
  logic [31:0] m_new = '0;
  logic [31:0] m_old = '0;
  logic [3:0]  m_wen = '0;
  logic [31:0] m_addr = '0;
  logic [31:0] m_wdata = '0;
  int          stall_cnt = 0;
  int          hs_cnt = 0;

  always @(negedge clk) begin
    if (m_active) begin
      check({m_name, "/stall"}, 32'(stall), 32'(m_t < m_t_end));
      check({m_name, "/bus_req"}, 32'(bus_req), 32'((m_t >= 1) && (m_t <= m_req_last)));
      check({m_name, "/mem_rdata"}, mem_rdata, (m_cap && m_t >= m_t_end) ? m_new : m_old);
      if (bus_req) begin
        check({m_name, "/bus_wr"}, 32'(bus_wr), 32'(m_wen != 4'd0));
        check({m_name, "/bus_size"}, 32'(bus_size), 32'(exp_size(m_wen)));
        check({m_name, "/bus_addr"}, bus_addr, m_addr);
        check({m_name, "/bus_wdata"}, bus_wdata, m_wdata);
        check({m_name, "/bus_wstrb"}, 32'(bus_wstrb), 32'(m_wen));
      end
      if (stall) stall_cnt++;
      if (bus_req && bus_addr_ok) hs_cnt++;
    end
  end

  // a_wait: ADDR cycles before addr_ok; d_wait: cycles from addr_ok to data_ok;
  // flush_t: cycle index of a one-cycle flush (-1 none); t=0 is the request cycle.
  task automatic run_scn(input string name, input logic [3:0] wen, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [31:0] rdata,
                         input int a_wait, input int d_wait, input int flush_t,
                         input int hold_n, input bit probe);
    int t_acc, t_dok, n;
    bit resp;
    t_acc = 1 + a_wait;
    t_dok = t_acc + d_wait;
    m_name = name; m_wen = wen; m_addr = addr; m_wdata = wdata; m_new = rdata;
    m_cap = (flush_t < 0);
    if (flush_t == 0) begin
      m_t_end = 0; m_req_last = 0; resp = 1'b0;
    end else if (flush_t > 0 && flush_t < t_acc) begin
      m_t_end = flush_t + 1; m_req_last = flush_t; resp = 1'b0;
    end else begin
      m_t_end = t_dok + 1; m_req_last = t_acc; resp = 1'b1;
    end
    n = m_t_end + hold_n + 3;
    stall_cnt = 0; hs_cnt = 0;
    m_active = 1'b1;
    for (int t = 0; t < n; t++) begin
      m_t = t;
      hold = m_cap && (t >= m_t_end) && (t < m_t_end + hold_n);
      if (t == 0) begin
        mem_en = 1'b1; mem_wen = wen; mem_addr = addr; mem_wdata = wdata;
      end else begin
        // New requests during hold must be ignored; elsewhere inputs are junk.
        mem_en = hold; mem_wen = 4'($urandom); mem_addr = $urandom; mem_wdata = $urandom;
      end
      flush = (t == flush_t);
      bus_addr_ok = resp && (t == t_acc);
      bus_data_ok = resp && (t == t_dok);
      bus_rdata = bus_data_ok ? rdata : $urandom;
      if (probe && t == 1) begin
        check({name, "/lit_wr"}, 32'(bus_wr), 32'd1);
        check({name, "/lit_size"}, 32'(bus_size), 32'd0);
        check({name, "/lit_wstrb"}, 32'(bus_wstrb), 32'b0100);
        check({name, "/lit_addr"}, bus_addr, 32'h0000_1002);
      end
      @(posedge clk); #1;
    end
    m_active = 1'b0;
    mem_en = 1'b0; hold = 1'b0; flush = 1'b0;
    bus_addr_ok = 1'b0; bus_data_ok = 1'b0;
    if (m_cap) m_old = m_new;
    $display("[TB] txn %s: stall_cycles=%0d handshakes=%0d mem_rdata=0x%08h",
             name, stall_cnt, hs_cnt, mem_rdata);
  endtask

  initial begin
    #1;
    check("reset/stall", 32'(stall), 32'd0);
    check("reset/bus_req", 32'(bus_req), 32'd0);
    check("reset/mem_rdata", mem_rdata, 32'd0);
    check("reset/bus_addr", bus_addr, 32'd0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;

    run_scn("word_read", 4'b0000, 32'h0000_1000, 32'h0, 32'hDEAD_BEEF, 0, 2, -1, 0, 1'b0);
    check("word_read/lit_stall_cycles", 32'(stall_cnt), 32'd4);
    check("word_read/lit_rdata", mem_rdata, 32'hDEAD_BEEF);

    run_scn("byte_write", 4'b0100, 32'h0000_1002, 32'hABAB_ABAB, 32'h0000_0077, 1, 1, -1, 0, 1'b1);
    check("byte_write/lit_handshakes", 32'(hs_cnt), 32'd1);

    run_scn("flush_data", 4'b0000, 32'h0000_1004, 32'h0, 32'h1234_5678, 0, 4, 2, 0, 1'b0);
    check("flush_data/lit_stall_cycles", 32'(stall_cnt), 32'd6);
    check("flush_data/lit_rdata_kept", mem_rdata, 32'h0000_0077);

    run_scn("hold_done", 4'b0000, 32'h0000_1008, 32'h0, 32'hCAFE_F00D, 1, 1, -1, 3, 1'b0);
    check("hold_done/lit_stall_cycles", 32'(stall_cnt), 32'd4);
    check("hold_done/lit_rdata", mem_rdata, 32'hCAFE_F00D);

    run_scn("same_cycle", 4'b0000, 32'h0000_100C, 32'h0, 32'h0000_0055, 0, 0, -1, 0, 1'b0);
    check("same_cycle/lit_stall_cycles", 32'(stall_cnt), 32'd2);
    check("same_cycle/lit_rdata", mem_rdata, 32'h0000_0055);

    run_scn("flush_idle", 4'b1111, 32'h0000_1010, 32'h1111_2222, 32'hFFFF_FFFF, 0, 1, 0, 0, 1'b0);
    check("flush_idle/lit_stall_cycles", 32'(stall_cnt), 32'd0);

    run_scn("flush_addr", 4'b0000, 32'h0000_1014, 32'h0, 32'hEEEE_EEEE, 3, 1, 2, 0, 1'b0);
    check("flush_addr/lit_stall_cycles", 32'(stall_cnt), 32'd3);
    check("flush_addr/lit_handshakes", 32'(hs_cnt), 32'd0);

    run_scn("half_write", 4'b1100, 32'h0000_1016, 32'h5A5A_5A5A, 32'h0000_0066, 2, 0, -1, 0, 1'b0);
    run_scn("flush_dok", 4'b0000, 32'h0000_1018, 32'h0, 32'h0BAD_0BAD, 0, 2, 3, 0, 1'b0);
    check("flush_dok/lit_rdata_kept", mem_rdata, 32'h0000_0066);

    // Asynchronous reset in the middle of a word write's DATA phase.
    mem_en = 1'b1; mem_wen = 4'b1111; mem_addr = 32'h0000_2000; mem_wdata = 32'h5A5A_5A5A;
    @(posedge clk); #1;
    mem_en = 1'b0; bus_addr_ok = 1'b1;
    @(posedge clk); #1;
    bus_addr_ok = 1'b0;
    check("rst_mid/pre_stall", 32'(stall), 32'd1);
    check("rst_mid/pre_bus_addr", bus_addr, 32'h0000_2000);
    #2 rst = 1'b0;
    #1;
    check("rst_mid/stall", 32'(stall), 32'd0);
    check("rst_mid/bus_req", 32'(bus_req), 32'd0);
    check("rst_mid/bus_wr", 32'(bus_wr), 32'd0);
    check("rst_mid/bus_size", 32'(bus_size), 32'd0);
    check("rst_mid/bus_addr", bus_addr, 32'd0);
    check("rst_mid/bus_wdata", bus_wdata, 32'd0);
    check("rst_mid/bus_wstrb", 32'(bus_wstrb), 32'd0);
    check("rst_mid/mem_rdata", mem_rdata, 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    bus_data_ok = 1'b1; bus_rdata = 32'h0000_0099;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      bus_data_ok = 1'b0;
      check("rst_after/stall", 32'(stall), 32'd0);
      check("rst_after/bus_req", 32'(bus_req), 32'd0);
      check("rst_after/mem_rdata", mem_rdata, 32'd0);
    end
    $display("[TB] txn rst_mid: mem_rdata=0x%08h stall=%0d", mem_rdata, stall);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/data_sram_bridge.md
# data_sram_bridge

Sequential bridge between the memory stage and the data-side SRAM-like bus. It captures the memory stage's single-cycle request (enable, byte write-enables, address, write data) and runs a req/addr_ok/data_ok handshake against a multi-cycle data port. It stalls the pipeline until the transaction completes and returns the raw read word for the memory stage to align and extend. It also handles exception flushes, including draining an already-accepted transaction.

## Interface
Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width (fixed 32; byte strobes are DATA_W/8 = 4)

Ports:
- clk  in  1  system clock; all state changes on rising edge
- rst  in  1  asynchronous, active-low reset
- mem_en  in  1  memory stage requests an access this cycle
- mem_wen  in  4  byte write-enables; 0 means read
- mem_addr  in  32  access address (already alignment-checked upstream)
- mem_wdata  in  32  write data, lane-replicated upstream
- mem_rdata  out  32  read word returned to the memory stage
- hold  in  1  a later stage stalls the pipeline; keep the completed result
- flush  in  1  exception/ERET flush; discard the in-flight access
- stall  out  1  freeze the pipeline at and before the memory stage
- bus_req  out  1  request valid
- bus_wr  out  1  1 = write
- bus_size  out  2  0 = byte, 1 = half, 2 = word
- bus_addr  out  32  request address
- bus_wdata  out  32  write data
- bus_wstrb  out  4  byte strobes
- bus_addr_ok  in  1  request accepted this cycle (valid only while bus_req = 1)
- bus_data_ok  in  1  read data / write ack returned this cycle
- bus_rdata  in  32  read data, valid with bus_data_ok

## Operation
- States: IDLE, ADDR, DATA, DONE, DRAIN.
- IDLE
  - On mem_en & ~flush: latch wen, addr and wdata into request registers, then go to ADDR.
  - bus_wr = |wen.
  - bus_size comes from the popcount of wen: 4→2, 2→1, 1→0. Reads always use size 2 with strobes 0000.
- ADDR
  - bus_req = 1 with the latched fields held stable.
  - addr_ok → DATA.
  - addr_ok & data_ok in the same cycle → DONE, capturing bus_rdata.
- DATA
  - bus_req = 0.
  - data_ok → DONE, capturing bus_rdata into rdata_q. Writes capture as well; the value is ignored.
- DONE
  - stall = 0 for this cycle.
  - ~hold → IDLE.
  - hold → remain in DONE. No new request is issued and rdata_q is held.
- DRAIN
  - Entered when a transaction was accepted but flushed.
  - Wait for data_ok, discard the data, then go to IDLE.
- stall = 1 in any of these cases:
  - ADDR, DATA or DRAIN
  - IDLE with mem_en & ~flush
  - otherwise 0
- mem_rdata = rdata_q at all times; it is updated only on capture.
- Flush rules:
  - IDLE: flush suppresses capture.
  - ADDR without addr_ok: drop bus_req and go to IDLE.
  - ADDR with addr_ok in the same cycle: go to DRAIN.
  - DATA without data_ok: go to DRAIN.
  - DATA with data_ok in the same cycle: go to IDLE without capture.
  - DONE: go to IDLE and leave rdata_q unchanged.
  - DRAIN: no effect.
- Only one outstanding transaction exists at any time.

## Timing
- Reset (rst low, asynchronous):
  - state = IDLE.
  - stall, bus_req, bus_wr, bus_size, bus_addr, bus_wdata, bus_wstrb and mem_rdata are all 0.
  - Reset mid-transaction abandons it; the bus side is reset by the same rst.
- Minimum latency: 2 stall cycles. Example with addr_ok & data_ok in the first ADDR cycle:
  - cycle 0: IDLE capture
  - cycle 1: ADDR
  - cycle 2: DONE, stall = 0
- General latency: 1 + (ADDR cycles) + (DATA cycles) stall cycles, followed by the DONE cycle.
- Request fields are registered outputs and do not change while bus_req = 1.
- Memory-stage inputs are sampled only in IDLE.

## Structure
- Shared package entries:
  - bridge_state_t enum (IDLE, ADDR, DATA, DONE, DRAIN)
  - bus size constants BUS_SZ_BYTE = 2'd0, BUS_SZ_HALF = 2'd1, BUS_SZ_WORD = 2'd2
  - function wen_to_size(wen)
- No sub-module; one FSM with request and result registers (~150–200 lines).

## Test plan
- Word read at 0x0000_1000. Drive addr_ok 1 cycle after req, then data_ok 2 cycles later with 0xDEADBEEF.
  - Expect: stall high for 4 cycles, DONE with mem_rdata = 0xDEADBEEF and stall = 0, then IDLE.
- Byte write with wen = 0100 at 0x0000_1002 and wdata 0xABABABAB.
  - Expect: bus_wr = 1, bus_size = 0, bus_wstrb = 0100, bus_addr = 0x0000_1002.
  - Expect: exactly one bus_req handshake.
- Read with flush asserted in DATA; data_ok arrives 3 cycles later with 0x12345678.
  - Expect: DRAIN, stall = 1 until data_ok, then IDLE.
  - Expect: mem_rdata keeps its previous value.
- hold high for 3 cycles in DONE after a read of 0xCAFEF00D.
  - Expect: state stays DONE, mem_rdata stable, bus_req = 0, then IDLE after hold falls.
- addr_ok & data_ok in the same ADDR cycle with rdata 0x00000055.
  - Expect: DONE on the next cycle with mem_rdata = 0x55.
- rst pulled low during DATA.
  - Expect: all outputs 0 immediately (asynchronously), state IDLE, and no DONE after release.
